// File: rtl/bram_sdp_be_init_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
//   Shared definitions for the byte-enable simple-dual-port block RAM and its
//   clear sequencer.
//
//   Contents:
//     RDW_OLD / RDW_NEW  - read-during-write selection values
//     init_state_e       - states of the post-reset clear sequencer
//     nb_bytes()         - number of write-enable lanes for a given word width
//     addr_w()           - address width needed for a given depth
// ---------------------------------------------------------------------------
package bram_pkg;

    // A same-address read on a write edge returns the word as it was before
    // the write.
    localparam int RDW_OLD = 0;

    // A same-address read on a write edge returns the merged word (written
    // lanes from the write data, the rest from the stored word).
    localparam int RDW_NEW = 1;

    // The clear sequencer is either idle (array belongs to the user ports) or
    // walking the array writing the clear value.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } init_state_e;

    // Lane count rounds up, so the top lane may be narrower than byte_width.
    function automatic int nb_bytes(input int width, input int byte_width);
        return (width + byte_width - 1) / byte_width;
    endfunction

    // At least one address bit, so a two-word array still has a real address.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_sdp_be_init_if.sv
// ---------------------------------------------------------------------------
// bram_sdp_be_init_if
//   Bundles the write port, the read port and the status outputs of the
//   byte-enable block RAM.
//
//   Signals:
//     ena, wea, addra, dia   - write port (enable, lane enables, address, data)
//     enb, addrb             - read port (enable, address)
//     dob, dob_valid         - read data and its one-cycle valid strobe
//     init_busy              - high while the clear sequencer owns the array
//
//   Modports:
//     master - the user of the memory (drives both ports)
//     slave  - the memory itself
// ---------------------------------------------------------------------------
interface bram_sdp_be_init_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 10,
    parameter int NB_BYTES   = 2
) ();

    logic                  ena;
    logic [NB_BYTES-1:0]   wea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_WIDTH-1:0] dia;
    logic                  enb;
    logic [ADDR_W-1:0]     addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;
    logic                  init_busy;

    modport master (
        output ena, wea, addra, dia, enb, addrb,
        input  dob, dob_valid, init_busy
    );

    modport slave (
        input  ena, wea, addra, dia, enb, addrb,
        output dob, dob_valid, init_busy
    );

endinterface

// File: rtl/bram_init_seq.sv
// ---------------------------------------------------------------------------
// bram_init_seq
//   Post-reset clear sequencer. After reset releases it walks every address
//   from 0 to DATA_DEPTH-1, asking the parent to write the clear value there,
//   one word per clock. init_busy is registered and drops on the same edge
//   that writes the last word, so it is high for exactly DATA_DEPTH cycles.
//
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset (restarts the clear)
//     init_busy  out  high while the clear owns the array
//     init_we    out  write strobe for the clear write this cycle
//     init_addr  out  address of the clear write this cycle
// ---------------------------------------------------------------------------
module bram_init_seq
    import bram_pkg::*;
#(
    parameter int DATA_DEPTH    = 1024,
    parameter int INIT_ON_RESET = 1,
    parameter int ADDR_W        = addr_w(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // Next-state logic. In CLEAR the counter advances once per cycle; the
    // cycle that services the last address returns to IDLE and releases the
    // busy flag on that same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers. Reset always parks the counter at address 0, so a
    // reset in the middle of a clear starts the walk over from the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= (INIT_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // While reset is held the counter is frozen at 0 and nothing is written.
    assign init_busy = busy_q;
    assign init_we   = (state_q == CLEAR) && !rst;
    assign init_addr = cnt_q;

endmodule

// File: rtl/bram_sdp_be_init.sv
// ---------------------------------------------------------------------------
// bram_sdp_be_init
//   Single-clock simple-dual-port RAM: port A writes with per-lane enables,
//   port B reads through one or two registers. A clear sequencer can fill the
//   array with INIT_VALUE after reset; while it runs, user writes are dropped
//   and reads are refused.
//
//   Ports:
//     clk   in     clock, rising edge
//     rst   in     synchronous active-high reset (never clears the array)
//     bus   slave  write port, read port, dob/dob_valid, init_busy
//
//   Parameters:
//     DATA_WIDTH, DATA_DEPTH, BYTE_WIDTH - geometry (top lane may be partial)
//     OUT_REG       - 0: read latency 1, 1: read latency 2
//     RDW_MODE      - RDW_OLD or RDW_NEW for same-address read/write
//     INIT_ON_RESET - 1: clear the array after every reset
//     INIT_VALUE    - word written by the clear
// ---------------------------------------------------------------------------
module bram_sdp_be_init
    import bram_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    DATA_DEPTH    = 1024,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    OUT_REG       = 1,
    parameter int                    RDW_MODE      = RDW_OLD,
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic               clk,
    input logic               rst,
    bram_sdp_be_init_if.slave bus
);

    localparam int NB_BYTES = nb_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int ADDR_W   = addr_w(DATA_DEPTH);

    // Depth widened by one bit so the range compare also works when the
    // depth is an exact power of two.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DATA_DEPTH);

    logic                  init_busy;
    logic                  init_we;
    logic [ADDR_W-1:0]     init_addr;

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [NB_BYTES-1:0]   lane_we;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic                  addra_in_range;
    logic                  addrb_in_range;
    logic                  porta_we;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;

    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] dob_q, dob_d;
    logic                  dob_valid_q, dob_valid_d;

    bram_init_seq #(
        .DATA_DEPTH    (DATA_DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET),
        .ADDR_W        (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // Expand the lane enables into a per-bit mask. Bit b belongs to lane
    // b / BYTE_WIDTH, which naturally gives the top lane only the bits that
    // exist when DATA_WIDTH is not a multiple of BYTE_WIDTH.
    assign lane_we = bus.wea;

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_lane_mask
        assign lane_mask[b] = lane_we[b / BYTE_WIDTH];
    end

    assign addra_in_range = ({1'b0, bus.addra} < DEPTH_EXT);
    assign addrb_in_range = ({1'b0, bus.addrb} < DEPTH_EXT);

    // A user write only lands when the clear is not running, the address is
    // inside the array and at least one lane is enabled.
    assign porta_we = bus.ena && !init_busy && addra_in_range && (|lane_we);

    // Single write path into the array: the clear sequencer takes it over
    // whenever it is active, otherwise port A drives it.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addra;
        wr_data = bus.dia;
        wr_mask = lane_mask;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_data = INIT_VALUE;
            wr_mask = '1;
        end else if (porta_we) begin
            wr_en = 1'b1;
        end
    end

    // Array write. Only the masked bits of the addressed word change, which
    // is what preserves the lanes that were not enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][b] <= wr_data[b];
                end
            end
        end
    end

    // Read lookup. An out-of-range address reads as zero but the read is
    // still accepted. The stored word is the pre-write value on a collision;
    // in RDW_NEW mode a bypass merges the incoming lanes over it so the
    // reader sees what the array will hold after this edge.
    assign rd_acc = bus.enb && !init_busy;

    always_comb begin
        rd_old  = addrb_in_range ? mem[bus.addrb] : '0;
        rd_word = rd_old;
        if ((RDW_MODE == RDW_NEW) && porta_we && (bus.addra == bus.addrb)) begin
            rd_word = (rd_old & ~lane_mask) | (bus.dia & lane_mask);
        end
    end

    // Output pipeline. With OUT_REG the accepted word first sits in stage 1
    // for one cycle; without it the word goes straight to dob. In both cases
    // dob keeps its last value whenever no read completes.
    always_comb begin
        s1_data_d   = s1_data_q;
        s1_valid_d  = 1'b0;
        dob_d       = dob_q;
        dob_valid_d = 1'b0;
        if (OUT_REG != 0) begin
            s1_valid_d = rd_acc;
            if (rd_acc) begin
                s1_data_d = rd_word;
            end
            dob_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dob_d = s1_data_q;
            end
        end else begin
            dob_valid_d = rd_acc;
            if (rd_acc) begin
                dob_d = rd_word;
            end
        end
    end

    // Output registers; reset empties the pipeline and zeroes dob.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            dob_q       <= '0;
            dob_valid_q <= 1'b0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            dob_q       <= dob_d;
            dob_valid_q <= dob_valid_d;
        end
    end

    assign bus.dob       = dob_q;
    assign bus.dob_valid = dob_valid_q;
    assign bus.init_busy = init_busy;

endmodule

// File: doc/bram_sdp_be_init.md
Name: bram_sdp_be_init

Overview:
Simple-dual-port, single-clock block RAM: write port A, registered read port B. Adds per-byte write enables, an optional output pipeline register, a selectable read-during-write collision mode and a post-reset memory-clear sequencer. It is the next-generation storage primitive under the FIFO cores; init_busy gates FIFO pointer logic until the clear completes.

Parameters:
DATA_WIDTH, 16, word width in bits (>=1)
DATA_DEPTH, 1024, number of words (>=2; need not be a power of 2)
BYTE_WIDTH, 8, bits per write-enable lane; NB_BYTES = ceil(DATA_WIDTH/BYTE_WIDTH); top lane may be partial
OUT_REG, 1, 0 = read latency 1; 1 = extra output register, read latency 2
RDW_MODE, 0, same-address read/write on the same edge: 0 = old data, 1 = new (merged) data
INIT_ON_RESET, 1, 1 = clear all words to INIT_VALUE after reset; 0 = contents untouched by reset
INIT_VALUE, 0, DATA_WIDTH-bit clear value

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
ena  in  1  port A enable
wea  in  NB_BYTES  byte-lane write enables; write lane i only when ena & wea[i]
addra  in  $clog2(DATA_DEPTH)  write address
dia  in  DATA_WIDTH  write data
enb  in  1  port B read enable
addrb  in  $clog2(DATA_DEPTH)  read address
dob  out  DATA_WIDTH  read data
dob_valid  out  1  high for one cycle when dob carries data for an accepted read
init_busy  out  1  high while the clear sequencer owns the array

Behaviour:
- Reset (rst sampled high): dob=0, dob_valid=0, pipeline valid bits=0; init_busy=1 if INIT_ON_RESET, else 0. The array is never cleared by rst directly.
- Init FSM states: IDLE, CLEAR. rst -> CLEAR with cnt=0 (INIT_ON_RESET=1), else IDLE. While rst stays high, cnt is held at 0 and no write occurs.
- CLEAR, rst low: write INIT_VALUE to ram[cnt] on every edge and increment cnt. On the edge that writes DATA_DEPTH-1, go to IDLE. init_busy is a register and falls on that same edge.
- init_busy is therefore high for exactly DATA_DEPTH cycles after rst deasserts.
- rst reasserted mid-CLEAR restarts the clear from address 0.
- During CLEAR, port A writes are dropped. enb reads are not accepted, and dob_valid stays 0.
- Read: an accepted read is enb=1 with init_busy=0 at edge N.
- OUT_REG=0: dob and dob_valid update at edge N.
- OUT_REG=1: stage-1 register is loaded at edge N; dob and dob_valid update at edge N+1.
- Back-to-back reads sustain one word per cycle.
- When no read completes, dob holds its last value and dob_valid=0.
- Write: each lane i with ena & wea[i] takes dia[lane i] at the edge. Lanes not enabled keep their contents. wea=0 is a no-op.
- Read-during-write, addra==addrb, write and read on the same edge:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word (written lanes from dia, other lanes from the old word). This is implemented as a bypass mux on the read path.
  - The array always ends with the merged word.
- Out-of-range address (>= DATA_DEPTH, non-power-of-2 depth): the write is dropped. The read is accepted, returns 0 and still asserts dob_valid.
- The partial top lane covers bits DATA_WIDTH-1 down to (NB_BYTES-1)*BYTE_WIDTH.

Decomposition:
- Shared package bram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1 constants
  - function nb_bytes(width, byte_width)
  - function addr_w(depth)
- Sub-module bram_init_seq holds the IDLE/CLEAR FSM and counter. Its outputs are init_busy, init_we and init_addr. The top level muxes its write over port A.

Test Plan:
- INIT_ON_RESET=1, DEPTH=16: rst high 3 cycles, then low -> init_busy high 16 cycles then 0. Reading addresses 0..15 returns INIT_VALUE (0xA5A5 in this test).
- Byte enables: write 0x1234 @5, then wea=2'b01 dia=0xFFAB @5 -> read @5 returns 0x12AB. Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), with dob_valid aligned to the data.
- RDW collision: ram[7]=0x1111, write 0x2222 @7 and read @7 on the same edge -> dob=0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1). A following read @7 returns 0x2222 in both modes.
- Reset mid-clear: assert rst at cnt=9 for 1 cycle -> the clear restarts at 0 and init_busy stays high a further DEPTH cycles. A port A write and a read issued during the clear are ignored (dob_valid=0, no data corruption).
- Streaming: 32 consecutive reads of addresses 0..31 -> dob_valid high 32 consecutive cycles with correct data. When enb drops, dob holds its last value and dob_valid=0.
- DEPTH=10, DATA_WIDTH=12, BYTE_WIDTH=8: write @12 is dropped and a read @12 returns 0 with dob_valid=1. wea=2'b10 writes only bits 11:8.
